// File: rtl/k12a_lcd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : k12a_lcd_sequencer
// Purpose  : FIFO-fed HD44780 write sequencer (setup / enable pulse / hold /
//            execution wait). Optional power-on init ROM: K12A_LCD_INIT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module k12a_lcd_sequencer #(
  parameter int FIFO_DEPTH   = 4,
  parameter int SETUP_CYCLES = 1,
  parameter int PULSE_CYCLES = 4,
  parameter int EXEC_CYCLES  = 40,
  parameter int CLEAR_CYCLES = 1600
) (
  input  logic                          cpu_clock,
  input  logic                          reset,
  input  logic                          wr_valid,
  input  logic                          wr_rs,
  input  logic [7:0]                    wr_data,
  output logic                          wr_ready,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          busy,
  output logic                          overflow,
  output logic                          lcd_rs,
  output logic                          lcd_rw,
  output logic                          lcd_en,
  output logic [7:0]                    lcd_data
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(CLEAR_CYCLES + 1);

  localparam logic [CW-1:0] SETUP_LOAD = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] EXEC_LOAD  = CW'(EXEC_CYCLES - 1);
  localparam logic [CW-1:0] CLEAR_LOAD = CW'(CLEAR_CYCLES - 1);
  localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);

`ifdef K12A_LCD_INIT_EN
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_PULSE = 3'd2,
    ST_HOLD  = 3'd3,
    ST_WAIT  = 3'd4,
    ST_INIT  = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_PULSE = 3'd2,
    ST_HOLD  = 3'd3,
    ST_WAIT  = 3'd4
  } state_t;
`endif

  state_t          state;
  state_t          state_next;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_next;

  logic [8:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [8:0]      head;
  logic            push;
  logic            pop;
  logic            load;
  logic            load_rs;
  logic [7:0]      load_data;
  logic            is_clear;

  assign wr_ready = (level != FULL_LEVEL);
  assign push     = wr_valid & wr_ready;
  assign head     = mem[rd_ptr];
  assign busy     = (state != ST_IDLE) || (level != '0);
  assign lcd_rw   = 1'b0;
  assign is_clear = !lcd_rs && ((lcd_data == 8'h01) || (lcd_data == 8'h02) ||
                                (lcd_data == 8'h03));

  // Storage is not reset; validity is tracked solely by level and the pointers.
  always_ff @(posedge cpu_clock) begin
    if (push) begin
      mem[wr_ptr] <= {wr_rs, wr_data};
    end
  end

  always_ff @(posedge cpu_clock) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      if (wr_valid && !wr_ready) begin
        overflow <= 1'b1;
      end
    end
  end

`ifdef K12A_LCD_INIT_EN
  logic       init_active;
  logic [1:0] init_idx;
  logic [7:0] init_byte;

  always_comb begin
    init_byte = 8'h38;
    case (init_idx)
      2'd0:    init_byte = 8'h38;
      2'd1:    init_byte = 8'h0C;
      2'd2:    init_byte = 8'h06;
      default: init_byte = 8'h01;
    endcase
  end

  always_ff @(posedge cpu_clock) begin
    if (reset) begin
      init_active <= 1'b1;
      init_idx    <= 2'd0;
    end else if (init_active && (state == ST_WAIT) && (cnt == '0)) begin
      if (init_idx == 2'd3) begin
        init_active <= 1'b0;
      end else begin
        init_idx <= init_idx + 2'd1;
      end
    end
  end
`endif

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    pop        = 1'b0;
    load       = 1'b0;
    load_rs    = head[8];
    load_data  = head[7:0];
    case (state)
      ST_IDLE: begin
        if (level != '0) begin
          pop        = 1'b1;
          load       = 1'b1;
          state_next = ST_SETUP;
          cnt_next   = SETUP_LOAD;
        end
      end
`ifdef K12A_LCD_INIT_EN
      ST_INIT: begin
        load       = 1'b1;
        load_rs    = 1'b0;
        load_data  = init_byte;
        state_next = ST_SETUP;
        cnt_next   = SETUP_LOAD;
      end
`endif
      ST_SETUP: begin
        if (cnt == '0) begin
          state_next = ST_PULSE;
          cnt_next   = PULSE_LOAD;
        end else begin
          cnt_next = cnt - CW'(1);
        end
      end
      ST_PULSE: begin
        if (cnt == '0) begin
          state_next = ST_HOLD;
        end else begin
          cnt_next = cnt - CW'(1);
        end
      end
      ST_HOLD: begin
        state_next = ST_WAIT;
        cnt_next   = is_clear ? CLEAR_LOAD : EXEC_LOAD;
      end
      ST_WAIT: begin
        if (cnt == '0) begin
`ifdef K12A_LCD_INIT_EN
          state_next = (init_active && (init_idx != 2'd3)) ? ST_INIT : ST_IDLE;
`else
          state_next = ST_IDLE;
`endif
        end else begin
          cnt_next = cnt - CW'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Pin outputs are registered; lcd_en mirrors the PULSE state with no lag.
  always_ff @(posedge cpu_clock) begin
    if (reset) begin
`ifdef K12A_LCD_INIT_EN
      state <= ST_INIT;
`else
      state <= ST_IDLE;
`endif
      cnt      <= '0;
      lcd_en   <= 1'b0;
      lcd_rs   <= 1'b0;
      lcd_data <= 8'h00;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      lcd_en <= (state_next == ST_PULSE);
      if (load) begin
        lcd_rs   <= load_rs;
        lcd_data <= load_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_k12a_lcd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_k12a_lcd_sequencer
// Purpose  : Directed self-checking bench for k12a_lcd_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_k12a_lcd_sequencer;

  logic       cpu_clock = 1'b0;
  logic       reset     = 1'b1;
  logic       wr_valid  = 1'b0;
  logic       wr_rs     = 1'b0;
  logic [7:0] wr_data   = 8'h00;
  logic       wr_ready;
  logic [2:0] level;
  logic       busy;
  logic       overflow;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_en;
  logic [7:0] lcd_data;

  int n_cmp = 0;
  int n_err = 0;

`ifdef K12A_LCD_INIT_EN
  localparam logic RESET_BUSY = 1'b1;
`else
  localparam logic RESET_BUSY = 1'b0;
`endif

  k12a_lcd_sequencer dut (
    .cpu_clock (cpu_clock),
    .reset     (reset),
    .wr_valid  (wr_valid),
    .wr_rs     (wr_rs),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .level     (level),
    .busy      (busy),
    .overflow  (overflow),
    .lcd_rs    (lcd_rs),
    .lcd_rw    (lcd_rw),
    .lcd_en    (lcd_en),
    .lcd_data  (lcd_data)
  );

  always #5 cpu_clock = ~cpu_clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge cpu_clock);
    #1;
  endtask

  task automatic push(input logic rs, input logic [7:0] d);
    wr_valid = 1'b1;
    wr_rs    = rs;
    wr_data  = d;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic do_reset();
    wr_valid = 1'b0;
    reset    = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_en(input logic val, input int bound, output int n);
    n = 0;
    while (lcd_en !== val && n < bound) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_idle(input string tag, input int bound, output int n);
    n = 0;
    while (busy !== 1'b0 && n < bound) begin
      tick();
      n++;
    end
    check(tag, busy, 1'b0);
  endtask

  task automatic wait_init();
`ifdef K12A_LCD_INIT_EN
    int n;
    wait_idle("init_done", 5000, n);
`endif
  endtask

  // Captures data/rs at each enable rise and compares with base+k.
  task automatic collect(input string tag, input int cnt, input logic [7:0] base);
    int n;
    for (int k = 0; k < cnt; k++) begin
      wait_en(1'b1, 300, n);
      check({tag, "_en"}, lcd_en, 1'b1);
      check({tag, "_data"}, lcd_data, base + 8'(k));
      check({tag, "_rs"}, lcd_rs, 1'b1);
      wait_en(1'b0, 10, n);
    end
  endtask

  initial begin
    int n;
    reset = 1'b1;
    tick();
    do_reset();

    // Reset state
    check("rst_en", lcd_en, 1'b0);
    check("rst_rs", lcd_rs, 1'b0);
    check("rst_data", lcd_data, 8'h00);
    check("rst_rw", lcd_rw, 1'b0);
    check("rst_level", level, 3'd0);
    check("rst_ovf", overflow, 1'b0);
    check("rst_ready", wr_ready, 1'b1);
    check("rst_busy", busy, RESET_BUSY);

`ifdef K12A_LCD_INIT_EN
    begin : init_seq
      logic [7:0] exp_b [5];
      exp_b = '{8'h38, 8'h0C, 8'h06, 8'h01, 8'h99};
      push(1'b1, 8'h99);
      for (int k = 0; k < 5; k++) begin
        wait_en(1'b1, 2000, n);
        check("init_en", lcd_en, 1'b1);
        check("init_data", lcd_data, exp_b[k]);
        check("init_rs", lcd_rs, (k == 4) ? 1'b1 : 1'b0);
        if (k == 4) check("init_user_gap", n, 1603);
        wait_en(1'b0, 10, n);
      end
      wait_idle("init_user_idle", 200, n);
    end
`endif

    // Single data write: timing of data, enable pulse and busy
    push(1'b1, 8'h41);
    check("nofall_level", level, 3'd1);
    check("nofall_data", lcd_data, 8'h00);
    tick();
    check("pop_data", lcd_data, 8'h41);
    check("pop_rs", lcd_rs, 1'b1);
    check("pop_level", level, 3'd0);
    check("setup_en", lcd_en, 1'b0);
    tick();
    check("pulse_en", lcd_en, 1'b1);
    wait_en(1'b0, 10, n);
    check("pulse_len", n, 4);
    repeat (40) tick();
    check("busy_late", busy, 1'b1);
    tick();
    check("busy_fall", busy, 1'b0);
    check("data_hold", lcd_data, 8'h41);

    // Clear instruction followed by data: long execution wait
    push(1'b0, 8'h01);
    push(1'b1, 8'h42);
    check("clr_data", lcd_data, 8'h01);
    check("clr_level", level, 3'd1);
    n = 0;
    while (lcd_data !== 8'h42 && n < 3000) begin
      tick();
      n++;
    end
    check("clr_period", n, 1607);
    wait_en(1'b1, 10, n);
    check("clr_next_en", n, 1);
    wait_idle("clr_idle", 200, n);

    // Fill to full, overflow, accepted order only
    fork
      begin
        for (int k = 0; k < 5; k++) push(1'b1, 8'h50 + 8'(k));
        check("full_level", level, 3'd4);
        check("full_ready", wr_ready, 1'b0);
        check("full_ovf0", overflow, 1'b0);
        push(1'b1, 8'h55);
        check("ovf_set", overflow, 1'b1);
        check("ovf_level", level, 3'd4);
      end
      collect("fill", 5, 8'h50);
    join
    wait_idle("fill_idle", 100, n);
    check("fill_tail", n, 41);
    check("fill_level0", level, 3'd0);
    check("ovf_sticky", overflow, 1'b1);

    // Reset during the enable pulse
    push(1'b1, 8'h77);
    push(1'b1, 8'h78);
    wait_en(1'b1, 10, n);
    check("mid_pulse", lcd_en, 1'b1);
    do_reset();
    check("mrst_en", lcd_en, 1'b0);
    check("mrst_level", level, 3'd0);
    check("mrst_data", lcd_data, 8'h00);
    check("mrst_rs", lcd_rs, 1'b0);
    check("mrst_ovf", overflow, 1'b0);
    wait_init();
    push(1'b1, 8'h79);
    tick();
    check("fresh_data", lcd_data, 8'h79);
    wait_en(1'b1, 5, n);
    check("fresh_setup", n, 1);
    wait_en(1'b0, 10, n);
    check("fresh_pulse", n, 4);
    wait_idle("fresh_idle", 100, n);
    check("fresh_wait", n, 41);

    // Push/pop in same cycle at level 2, pointer wrap over 12 entries
    fork
      begin
        push(1'b1, 8'h00);
        push(1'b1, 8'h01);
        push(1'b1, 8'h02);
        check("lvl2_pre", level, 3'd2);
        repeat (45) tick();
        check("lvl2_hold", level, 3'd2);
        push(1'b1, 8'h03);
        check("lvl2_pushpop", level, 3'd2);
        for (int v = 4; v < 12; v++) begin
          n = 0;
          while (wr_ready !== 1'b1 && n < 500) begin
            tick();
            n++;
          end
          check("feed_ready", wr_ready, 1'b1);
          push(1'b1, 8'(v));
        end
      end
      collect("wrap", 12, 8'h00);
    join
    wait_idle("wrap_idle", 200, n);
    check("wrap_ovf", overflow, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
